// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, byte hand-off struct and
// the baud divisor helper also used by the TX side.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_FSM_IDLE  = 2'd0,
        UART_FSM_START = 2'd1,
        UART_FSM_DATA  = 2'd2,
        UART_FSM_STOP  = 2'd3
    } uart_fsm_e;

    // One received byte handed from the bit engine to the FIFO
    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } rx_byte_t;

    // Clock cycles per bit, rounded to nearest
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word. Pointers wrap
// modulo DEPTH, occupancy is kept in its own counter so full/empty never alias.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]    count, count_d;
    logic [WIDTH-1:0] head, head_d;
    logic             empty, full, pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop on empty is ignored; a full FIFO still accepts a push that is
    // paired with a pop, since a slot frees up on the same edge.
    assign pop_ok  = i_pop & ~empty;
    assign push_ok = i_push & (~full | pop_ok);
    assign o_drop  = i_push & full & ~i_pop;
    assign rd_nxt  = rd_ptr + AW'(1);
    assign count_d = count + CW'(push_ok) - CW'(pop_ok);

    // Next head word: the entry behind the popped one, or fresh write data
    // when that entry is being written this same cycle or the FIFO was empty.
    always_comb begin
        head_d = head;
        if (pop_ok) begin
            if (count == CW'(1)) begin
                if (push_ok) head_d = i_wdata;
            end else begin
                head_d = mem[rd_nxt];
            end
        end else if (empty && push_ok) begin
            head_d = i_wdata;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_wdata;
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_nxt;
            count <= count_d;
            head  <= head_d;
        end
    end

    assign o_rdata = head;
    assign o_count = count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: RX pin synchroniser, 8N1 mid-bit sampling FSM and a
// small byte FIFO feeding the MMIO/IRQ logic.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 2_000_000,
    parameter int DEPTH     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_uart_rx,
    input  logic                   i_rx_pop,
    input  logic                   i_err_clr,
    output logic [7:0]             o_rx_data,
    output logic                   o_rx_pending,
    output logic [$clog2(DEPTH):0] o_rx_count,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam int BIT   = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = BIT / 2;
    localparam int CTR_W = $clog2(BIT);

    logic             rst_meta, rst_n_int;
    logic             rx_s1, rx_s2, rx_prev, start_edge;
    uart_fsm_e        state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    rx_byte_t         push;
    logic             ferr_set, drop;

    // Reset asserts immediately, releases on a clock edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // A held-low line never re-triggers: a start needs a genuine 1->0 edge
    assign start_edge = rx_prev & ~rx_s2;

    // Receiver state, bit-timing counter, bit index and shift register
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= UART_FSM_IDLE;
            ctr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Frame recovery: wait half a bit to land mid-bit, then sample every BIT
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = '0;
        ferr_set  = 1'b0;
        case (state_q)
            UART_FSM_IDLE: begin
                if (start_edge) begin
                    ctr_d   = CTR_W'(HALF - 1);
                    state_d = UART_FSM_START;
                end
            end
            UART_FSM_START: begin
                if (ctr_q == '0) begin
                    if (!rx_s2) begin
                        ctr_d   = CTR_W'(BIT - 1);
                        bit_d   = '0;
                        state_d = UART_FSM_DATA;
                    end else begin
                        state_d = UART_FSM_IDLE;   // glitch, not a real start bit
                    end
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            UART_FSM_DATA: begin
                if (ctr_q == '0) begin
                    shreg_d = {rx_s2, shreg_q[7:1]};
                    ctr_d   = CTR_W'(BIT - 1);
                    if (bit_q == 3'd7) state_d = UART_FSM_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            UART_FSM_STOP: begin
                if (ctr_q == '0) begin
                    if (rx_s2) begin
                        push.vld  = 1'b1;
                        push.data = shreg_q;
                    end else begin
                        ferr_set = 1'b1;
                    end
                    state_d = UART_FSM_IDLE;
                end else begin
                    ctr_d = ctr_q - CTR_W'(1);
                end
            end
            default: state_d = UART_FSM_IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (rst_n_int),
        .i_push  (push.vld),
        .i_wdata (push.data),
        .i_pop   (i_rx_pop),
        .o_rdata (o_rx_data),
        .o_count (o_rx_count),
        .o_drop  (drop)
    );

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (ferr_set)       o_frame_err <= 1'b1;
            else if (i_err_clr) o_frame_err <= 1'b0;
            if (drop)           o_overrun   <= 1'b1;
            else if (i_err_clr) o_overrun   <= 1'b0;
        end
    end

    assign o_rx_pending = (o_rx_count != '0);
    assign o_busy       = (state_q != UART_FSM_IDLE);

endmodule
